// File: rtl/prt_riscv_cpu_wb_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : prt_riscv_cpu_wb_arb_if
//  Description : EX/LD write-back requests, load-issue, operand-read and
//                register-file write-port signals of the write-back arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prt_riscv_cpu_wb_arb_if #(
    parameter int P_IDX = 4
);
    logic [P_IDX-1:0] EX_IDX_IN;
    logic [31:0]      EX_DAT_IN;
    logic             EX_VLD_IN;
    logic             EX_RDY_OUT;
    logic [P_IDX-1:0] LD_IDX_IN;
    logic [31:0]      LD_DAT_IN;
    logic             LD_VLD_IN;
    logic             LD_RDY_OUT;
    logic             LD_ISS_IN;
    logic [P_IDX-1:0] LD_ISS_IDX_IN;
    logic [P_IDX-1:0] RS1_IDX_IN;
    logic [P_IDX-1:0] RS2_IDX_IN;
    logic             HAZ_OUT;
    logic [P_IDX-1:0] RD_IDX_OUT;
    logic [31:0]      RD_DAT_OUT;
    logic             RD_WR_OUT;

    modport master (
        output EX_IDX_IN, EX_DAT_IN, EX_VLD_IN,
        output LD_IDX_IN, LD_DAT_IN, LD_VLD_IN,
        output LD_ISS_IN, LD_ISS_IDX_IN, RS1_IDX_IN, RS2_IDX_IN,
        input  EX_RDY_OUT, LD_RDY_OUT, HAZ_OUT,
        input  RD_IDX_OUT, RD_DAT_OUT, RD_WR_OUT
    );

    modport slave (
        input  EX_IDX_IN, EX_DAT_IN, EX_VLD_IN,
        input  LD_IDX_IN, LD_DAT_IN, LD_VLD_IN,
        input  LD_ISS_IN, LD_ISS_IDX_IN, RS1_IDX_IN, RS2_IDX_IN,
        output EX_RDY_OUT, LD_RDY_OUT, HAZ_OUT,
        output RD_IDX_OUT, RD_DAT_OUT, RD_WR_OUT
    );
endinterface
`default_nettype wire

// File: rtl/prt_riscv_cpu_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : prt_riscv_cpu_wb_arb
//  Description : Round-robin EX/LD arbiter for the register-file write port
//                with a pending-load scoreboard and RAW/WAW hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module prt_riscv_cpu_wb_arb #(
    parameter int P_REGS = 16,
    parameter int P_IDX  = 4
) (
    input  wire logic               CLK_IN,
    input  wire logic               RSTN_IN,
    prt_riscv_cpu_wb_arb_if.slave   bus
);

    typedef enum logic [0:0] {
        GNT_EX = 1'b0,
        GNT_LD = 1'b1
    } grant_t;

    grant_t            r_last;
    grant_t            w_last_nxt;
    logic [P_REGS-1:0] r_pend;
    logic [P_REGS-1:0] w_pend_nxt;
    logic              r_rd_wr;
    logic              w_rd_wr_nxt;
    logic [P_IDX-1:0]  r_rd_idx;
    logic [P_IDX-1:0]  w_rd_idx_nxt;
    logic [31:0]       r_rd_dat;
    logic [31:0]       w_rd_dat_nxt;
    logic              w_ex_elig;
    logic              w_ld_elig;
    logic              w_gnt_ex;
    logic              w_gnt_ld;
    logic              w_haz1;
    logic              w_haz2;

    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            r_last   <= GNT_EX;
            r_pend   <= '0;
            r_rd_wr  <= 1'b0;
            r_rd_idx <= '0;
            r_rd_dat <= '0;
        end else begin
            r_last   <= w_last_nxt;
            r_pend   <= w_pend_nxt;
            r_rd_wr  <= w_rd_wr_nxt;
            r_rd_idx <= w_rd_idx_nxt;
            r_rd_dat <= w_rd_dat_nxt;
        end
    end

    always_comb begin
        w_last_nxt   = r_last;
        w_pend_nxt   = r_pend;
        w_rd_wr_nxt  = 1'b0;
        w_rd_idx_nxt = r_rd_idx;
        w_rd_dat_nxt = r_rd_dat;

        // EX may not retire onto a register an older load still owns
        w_ex_elig = bus.EX_VLD_IN & ~r_pend[bus.EX_IDX_IN];
        w_ld_elig = bus.LD_VLD_IN;
        w_gnt_ex  = w_ex_elig & (~w_ld_elig | (r_last == GNT_LD));
        w_gnt_ld  = w_ld_elig & (~w_ex_elig | (r_last == GNT_EX));

        if (w_gnt_ex) begin
            w_last_nxt   = GNT_EX;
            w_rd_wr_nxt  = |bus.EX_IDX_IN;
            w_rd_idx_nxt = bus.EX_IDX_IN;
            w_rd_dat_nxt = bus.EX_DAT_IN;
        end else if (w_gnt_ld) begin
            w_last_nxt   = GNT_LD;
            w_rd_wr_nxt  = |bus.LD_IDX_IN;
            w_rd_idx_nxt = bus.LD_IDX_IN;
            w_rd_dat_nxt = bus.LD_DAT_IN;
        end

        // Clear first so a same-cycle issue to that index keeps it pending
        if (w_gnt_ld)
            w_pend_nxt[bus.LD_IDX_IN] = 1'b0;
        if (bus.LD_ISS_IN)
            w_pend_nxt[bus.LD_ISS_IDX_IN] = 1'b1;
        w_pend_nxt[0] = 1'b0;

        // An in-flight write has not reached the register-file read port yet
        w_haz1 = (bus.RS1_IDX_IN != '0) &
                 (r_pend[bus.RS1_IDX_IN] | (r_rd_wr & (r_rd_idx == bus.RS1_IDX_IN)));
        w_haz2 = (bus.RS2_IDX_IN != '0) &
                 (r_pend[bus.RS2_IDX_IN] | (r_rd_wr & (r_rd_idx == bus.RS2_IDX_IN)));
    end

    assign bus.EX_RDY_OUT = w_gnt_ex;
    assign bus.LD_RDY_OUT = w_gnt_ld;
    assign bus.HAZ_OUT    = w_haz1 | w_haz2;
    assign bus.RD_WR_OUT  = r_rd_wr;
    assign bus.RD_IDX_OUT = r_rd_idx;
    assign bus.RD_DAT_OUT = r_rd_dat;

endmodule
`default_nettype wire

// File: tb/tb_prt_riscv_cpu_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prt_riscv_cpu_wb_arb
//  Description : Directed self-checking bench for prt_riscv_cpu_wb_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prt_riscv_cpu_wb_arb;

    logic CLK_IN;
    logic RSTN_IN;
    int   n_checks;
    int   n_errors;

    prt_riscv_cpu_wb_arb_if #(.P_IDX(4)) bus ();

    prt_riscv_cpu_wb_arb #(
        .P_REGS (16),
        .P_IDX  (4)
    ) u_dut (
        .CLK_IN  (CLK_IN),
        .RSTN_IN (RSTN_IN),
        .bus     (bus)
    );

    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    initial begin
        logic [3:0] exp_idx [4];
        logic       exp_ld  [4];
        n_checks = 0;
        n_errors = 0;
        RSTN_IN  = 1'b0;
        bus.EX_IDX_IN = '0; bus.EX_DAT_IN = '0; bus.EX_VLD_IN = 1'b0;
        bus.LD_IDX_IN = '0; bus.LD_DAT_IN = '0; bus.LD_VLD_IN = 1'b0;
        bus.LD_ISS_IN = 1'b0; bus.LD_ISS_IDX_IN = '0;
        bus.RS1_IDX_IN = '0; bus.RS2_IDX_IN = '0;

        // Reset state
        tick(); tick();
        chk("rst_wr",  {31'd0, bus.RD_WR_OUT}, 32'd0);
        chk("rst_idx", {28'd0, bus.RD_IDX_OUT}, 32'd0);
        chk("rst_dat", bus.RD_DAT_OUT, 32'd0);
        chk("rst_haz", {31'd0, bus.HAZ_OUT}, 32'd0);
        RSTN_IN = 1'b1;
        tick();

        // 1. EX only
        bus.EX_IDX_IN = 4'd5; bus.EX_DAT_IN = 32'h1234_5678; bus.EX_VLD_IN = 1'b1;
        #1;
        chk("t1_ex_rdy", {31'd0, bus.EX_RDY_OUT}, 32'd1);
        chk("t1_ld_rdy", {31'd0, bus.LD_RDY_OUT}, 32'd0);
        tick();
        bus.EX_VLD_IN = 1'b0; bus.RS1_IDX_IN = 4'd5;
        #1;
        chk("t1_wr",  {31'd0, bus.RD_WR_OUT}, 32'd1);
        chk("t1_idx", {28'd0, bus.RD_IDX_OUT}, 32'd5);
        chk("t1_dat", bus.RD_DAT_OUT, 32'h1234_5678);
        chk("t1_haz_inflight", {31'd0, bus.HAZ_OUT}, 32'd1);
        tick();
        chk("t1_wr_off",  {31'd0, bus.RD_WR_OUT}, 32'd0);
        chk("t1_idx_hold", {28'd0, bus.RD_IDX_OUT}, 32'd5);
        chk("t1_haz_off", {31'd0, bus.HAZ_OUT}, 32'd0);
        bus.RS1_IDX_IN = 4'd0;

        // 2. Both valid four cycles, last grant EX -> LD,EX,LD,EX
        exp_idx = '{4'd2, 4'd1, 4'd2, 4'd1};
        exp_ld  = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.EX_IDX_IN = 4'd1; bus.EX_DAT_IN = 32'hA1A1_A1A1; bus.EX_VLD_IN = 1'b1;
        bus.LD_IDX_IN = 4'd2; bus.LD_DAT_IN = 32'hB2B2_B2B2; bus.LD_VLD_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t2_ld_rdy%0d", i), {31'd0, bus.LD_RDY_OUT}, {31'd0, exp_ld[i]});
            chk($sformatf("t2_ex_rdy%0d", i), {31'd0, bus.EX_RDY_OUT}, {31'd0, ~exp_ld[i]});
            tick();
            chk($sformatf("t2_idx%0d", i), {28'd0, bus.RD_IDX_OUT}, {28'd0, exp_idx[i]});
            chk($sformatf("t2_dat%0d", i), bus.RD_DAT_OUT, exp_ld[i] ? 32'hB2B2_B2B2 : 32'hA1A1_A1A1);
        end
        bus.EX_VLD_IN = 1'b0; bus.LD_VLD_IN = 1'b0;
        tick();

        // 3. Load to 3 pending -> RS1 hazard until write retires
        bus.LD_ISS_IN = 1'b1; bus.LD_ISS_IDX_IN = 4'd3; bus.RS1_IDX_IN = 4'd3;
        #1;
        chk("t3_haz_preiss", {31'd0, bus.HAZ_OUT}, 32'd0);
        tick();
        bus.LD_ISS_IN = 1'b0;
        #1;
        chk("t3_haz_pend", {31'd0, bus.HAZ_OUT}, 32'd1);
        bus.RS1_IDX_IN = 4'd0;
        #1;
        chk("t3_haz_rs0", {31'd0, bus.HAZ_OUT}, 32'd0);
        bus.RS1_IDX_IN = 4'd3;
        bus.LD_IDX_IN = 4'd3; bus.LD_DAT_IN = 32'h3333_3333; bus.LD_VLD_IN = 1'b1;
        #1;
        chk("t3_ld_rdy", {31'd0, bus.LD_RDY_OUT}, 32'd1);
        chk("t3_haz_acc", {31'd0, bus.HAZ_OUT}, 32'd1);
        tick();
        bus.LD_VLD_IN = 1'b0;
        #1;
        chk("t3_wr", {31'd0, bus.RD_WR_OUT}, 32'd1);
        chk("t3_haz_inflight", {31'd0, bus.HAZ_OUT}, 32'd1);
        tick();
        chk("t3_haz_clear", {31'd0, bus.HAZ_OUT}, 32'd0);
        bus.RS1_IDX_IN = 4'd0;

        // 4. WAW: EX to 7 blocked while load on 7 pending
        bus.LD_ISS_IN = 1'b1; bus.LD_ISS_IDX_IN = 4'd7;
        tick();
        bus.LD_ISS_IN = 1'b0;
        bus.EX_IDX_IN = 4'd7; bus.EX_DAT_IN = 32'h7777_7777; bus.EX_VLD_IN = 1'b1;
        #1;
        chk("t4_ex_blk0", {31'd0, bus.EX_RDY_OUT}, 32'd0);
        tick();
        chk("t4_ex_blk1", {31'd0, bus.EX_RDY_OUT}, 32'd0);
        chk("t4_wr_idle", {31'd0, bus.RD_WR_OUT}, 32'd0);
        bus.LD_IDX_IN = 4'd7; bus.LD_DAT_IN = 32'h7070_7070; bus.LD_VLD_IN = 1'b1;
        #1;
        chk("t4_ld_rdy", {31'd0, bus.LD_RDY_OUT}, 32'd1);
        chk("t4_ex_blk2", {31'd0, bus.EX_RDY_OUT}, 32'd0);
        tick();
        bus.LD_VLD_IN = 1'b0;
        #1;
        chk("t4_ex_rdy", {31'd0, bus.EX_RDY_OUT}, 32'd1);
        chk("t4_ld_dat", bus.RD_DAT_OUT, 32'h7070_7070);
        tick();
        bus.EX_VLD_IN = 1'b0;
        chk("t4_ex_dat", bus.RD_DAT_OUT, 32'h7777_7777);
        chk("t4_ex_idx", {28'd0, bus.RD_IDX_OUT}, 32'd7);
        tick();

        // 5. Same-cycle issue and retire on 4: set wins
        bus.LD_ISS_IN = 1'b1; bus.LD_ISS_IDX_IN = 4'd4;
        tick();
        bus.LD_IDX_IN = 4'd4; bus.LD_DAT_IN = 32'h4444_4444; bus.LD_VLD_IN = 1'b1;
        bus.RS2_IDX_IN = 4'd4;
        #1;
        chk("t5_ld_rdy", {31'd0, bus.LD_RDY_OUT}, 32'd1);
        tick();
        bus.LD_ISS_IN = 1'b0; bus.LD_VLD_IN = 1'b0;
        #1;
        chk("t5_haz0", {31'd0, bus.HAZ_OUT}, 32'd1);
        tick();
        chk("t5_wr_off", {31'd0, bus.RD_WR_OUT}, 32'd0);
        chk("t5_haz1", {31'd0, bus.HAZ_OUT}, 32'd1);

        // 6. Write to x0, then async reset mid-stream
        bus.EX_IDX_IN = 4'd0; bus.EX_DAT_IN = 32'hDEAD_BEEF; bus.EX_VLD_IN = 1'b1;
        #1;
        chk("t6_x0_rdy", {31'd0, bus.EX_RDY_OUT}, 32'd1);
        tick();
        bus.EX_VLD_IN = 1'b0;
        #1;
        chk("t6_x0_wr", {31'd0, bus.RD_WR_OUT}, 32'd0);
        bus.LD_ISS_IN = 1'b1; bus.LD_ISS_IDX_IN = 4'd9;
        bus.EX_IDX_IN = 4'd6; bus.EX_DAT_IN = 32'h6666_6666; bus.EX_VLD_IN = 1'b1;
        tick();
        bus.LD_ISS_IN = 1'b0; bus.RS1_IDX_IN = 4'd9; bus.RS2_IDX_IN = 4'd0;
        #1;
        chk("t6_wr_pre", {31'd0, bus.RD_WR_OUT}, 32'd1);
        chk("t6_haz_pre", {31'd0, bus.HAZ_OUT}, 32'd1);
        RSTN_IN = 1'b0;
        #1;
        chk("t6_rst_wr",  {31'd0, bus.RD_WR_OUT}, 32'd0);
        chk("t6_rst_idx", {28'd0, bus.RD_IDX_OUT}, 32'd0);
        chk("t6_rst_dat", bus.RD_DAT_OUT, 32'd0);
        chk("t6_rst_haz", {31'd0, bus.HAZ_OUT}, 32'd0);
        bus.RS2_IDX_IN = 4'd4;
        #1;
        chk("t6_rst_pend4", {31'd0, bus.HAZ_OUT}, 32'd0);
        bus.EX_VLD_IN = 1'b0;
        tick();
        RSTN_IN = 1'b1;
        tick();
        chk("t6_post_wr", {31'd0, bus.RD_WR_OUT}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
